seg7_scan_driver: RTL and testbench

Parametrised, time-multiplexed hex 7-segment display driver for DIGITS common-anode digits, with per-digit decimal point and blanking. A prescaler sets the scan rate; a frame-synchronous load handshake prevents tearing. It sits between the PS/2 keyboard datapath (or any status source) and the board display pins, and replaces the single-digit combinational decoder.

---
 rtl/seg7_pkg.sv | 19 +
 rtl/seg7_decode.sv | 11 +
 rtl/seg7_scan_driver.sv | 120 ++++++++++++
 tb/tb_seg7_scan_driver.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: segment table, blank pattern and anode helper shared by the
// seg7_scan_driver files.
package seg7_pkg;

  localparam int MAX_DIGITS = 8;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {a,b,c,d,e,f,g} pattern for each hex value.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  function automatic logic [MAX_DIGITS-1:0] an_pattern(input logic [2:0] idx, input logic off);
    return off ? '1 : ~(MAX_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational hex nibble to active-low 7-segment pattern.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_TABLE[i_nib];

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed hex display driver with frame-synchronous load.
// Optional SEG7_LEADING_ZERO_BLANK_EN darkens digits above the top non-zero nibble.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic                  load,
  output logic                  load_pending,
  output logic                  load_ack,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CW-1:0]          r_cnt;
  logic [IW-1:0]          r_idx;
  logic [DIGITS-1:0][3:0] r_sh_data, r_disp_data;
  logic [DIGITS-1:0]      r_sh_dp, r_sh_blank, r_disp_dp, r_disp_blank;
  logic                   r_pending, r_ack;
  logic [6:0]             r_seg;
  logic                   r_dp;
  logic [DIGITS-1:0]      r_an;

  logic                   w_tick, w_frame, w_commit, w_blank;
  logic [DIGITS-1:0][3:0] w_data_in;
  logic [DIGITS-1:0]      w_lz;
  logic [3:0]             w_nib;
  logic [6:0]             w_seg;
  logic [MAX_DIGITS-1:0]  w_an;

  assign w_data_in = data_in;
  assign w_tick    = r_cnt == CW'(PRESCALE - 1);
  assign w_frame   = w_tick && (r_idx == IW'(DIGITS - 1));
  assign w_commit  = w_frame && (r_pending || load);

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic w_zero;
  // Walk down from the top digit; digit 0 is never auto-blanked.
  always_comb begin
    w_lz   = '0;
    w_zero = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      w_zero  = w_zero && (r_disp_data[i] == 4'h0);
      w_lz[i] = w_zero;
    end
  end
`else
  assign w_lz = '0;
`endif

  assign w_nib   = r_disp_data[r_idx];
  assign w_blank = r_disp_blank[r_idx] || w_lz[r_idx];
  assign w_an    = an_pattern(3'(r_idx), r_cnt == '0);

  seg7_decode u_decode (
    .i_nib (w_nib),
    .o_seg (w_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_sh_data    <= '0;
      r_sh_dp      <= '0;
      r_sh_blank   <= '0;
      r_disp_data  <= '0;
      r_disp_dp    <= '0;
      r_disp_blank <= '0;
      r_pending    <= 1'b0;
      r_ack        <= 1'b0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
      if (w_tick)
        r_idx <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);
      r_ack <= w_commit;
      if (w_commit) begin
        r_disp_data  <= load ? w_data_in : r_sh_data;
        r_disp_dp    <= load ? dp_in     : r_sh_dp;
        r_disp_blank <= load ? blank_in  : r_sh_blank;
        r_pending    <= 1'b0;
      end else if (load) begin
        r_sh_data    <= w_data_in;
        r_sh_dp      <= dp_in;
        r_sh_blank   <= blank_in;
        r_pending    <= 1'b1;
      end
    end
  end

  // Pins lag the scan state by one cycle; an auto-blanked digit keeps its dp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
      r_an  <= '1;
    end else begin
      r_seg <= w_blank ? SEG_BLANK : w_seg;
      r_dp  <= r_disp_blank[r_idx] ? 1'b1 : ~r_disp_dp[r_idx];
      r_an  <= w_an[DIGITS-1:0];
    end
  end

  assign seg          = r_seg;
  assign dp           = r_dp;
  assign an           = r_an;
  assign load_ack     = r_ack;
  assign load_pending = r_pending;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: randomized and directed scan/load checks against a
// time-indexed reference model (DIGITS=4, PRESCALE=4).
module tb_seg7_scan_driver;

  localparam int D = 4;
  localparam int P = 4;
  localparam int F = D * P;

  localparam logic [6:0] SEG_REF [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic        load_pending, load_ack, dp;
  logic [6:0]  seg;
  logic [3:0]  an;

  int n_vec = 0;
  int n_err = 0;
  int t = 0;

  logic [15:0] m_dd, s_dd;
  logic [3:0]  m_dp, m_db, s_dp, s_db;
  logic        m_pend;

  seg7_scan_driver #(.DIGITS(D), .PRESCALE(P)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .dp_in        (dp_in),
    .blank_in     (blank_in),
    .load         (load),
    .load_pending (load_pending),
    .load_ack     (load_ack),
    .seg          (seg),
    .dp           (dp),
    .an           (an)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
    end
  endtask

  task automatic model_reset();
    t = 0;
    {m_dd, m_dp, m_db, s_dd, s_dp, s_db, m_pend} = '0;
  endtask

  // One clock: expected pins follow from the pre-edge time slot and display.
  task automatic step(input logic l, input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    int cnt, idx;
    logic auto_b, e_dp, e_ack;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    cnt = t % P;
    idx = (t / P) % D;
    auto_b = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    auto_b = (idx > 0) && ((m_dd >> (4 * idx)) == 16'h0);
`endif
    e_an  = (cnt == 0) ? 4'hF : ~(4'b0001 << idx);
    e_seg = (m_db[idx] || auto_b) ? 7'h7F : SEG_REF[4'(m_dd >> (4 * idx))];
    e_dp  = m_db[idx] ? 1'b1 : ~m_dp[idx];
    e_ack = (t % F == F - 1) && (m_pend || l);
    if (e_ack) begin
      {m_dd, m_dp, m_db} = l ? {d, p, b} : {s_dd, s_dp, s_db};
      m_pend = 1'b0;
    end else if (l) begin
      {s_dd, s_dp, s_db} = {d, p, b};
      m_pend = 1'b1;
    end
    load = l;
    data_in = d;
    dp_in = p;
    blank_in = b;
    @(posedge clk);
    #1;
    check("seg", 32'(seg), 32'(e_seg));
    check("dp", 32'(dp), 32'(e_dp));
    check("an", 32'(an), 32'(e_an));
    check("load_ack", 32'(load_ack), 32'(e_ack));
    check("load_pending", 32'(load_pending), 32'(m_pend));
    t++;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
  endtask

  task automatic idle_to(input int ph);
    while (t % F != ph) idle(1);
  endtask

  initial begin
    logic [15:0] sweep [4];
    logic [15:0] rd;
    sweep = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_an", 32'(an), 32'hF);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 4; k++) begin
      idle_to(F - 1);
      step(1'b1, sweep[k], 4'h0, 4'h0);
      idle(F);
    end

    idle_to(5);
    step(1'b1, 16'hBEEF, 4'h0, 4'h0);
    idle(F + 4);

    idle_to(2);
    step(1'b1, 16'h1111, 4'h0, 4'h0);
    idle_to(9);
    step(1'b1, 16'h2222, 4'h0, 4'h0);
    idle(F + 4);

    idle_to(F - 1);
    step(1'b1, 16'hA5A5, 4'h0, 4'h0);
    idle(F + 1);

    idle_to(F - 1);
    step(1'b1, 16'h0070, 4'b0001, 4'h0);
    idle(F + 1);

    idle_to(F - 1);
    step(1'b1, 16'h4321, 4'b1010, 4'b0100);
    idle(F + 1);

    // Asynchronous reset while load_ack is high, mid-scan.
    idle_to(F - 1);
    step(1'b1, 16'h9876, 4'hF, 4'h0);
    rst_n = 1'b0;
    #1;
    check("arst_seg", 32'(seg), 32'h7F);
    check("arst_dp", 32'(dp), 32'h1);
    check("arst_an", 32'(an), 32'hF);
    check("arst_ack", 32'(load_ack), 32'h0);
    check("arst_pending", 32'(load_pending), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(F + 2);

    for (int i = 0; i < 1500; i++) begin
      rd = 16'($urandom);
      if ($urandom_range(0, 1) == 0) rd = rd >> (4 * $urandom_range(1, 4));
      step($urandom_range(0, 7) == 0, rd, 4'($urandom),
           ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
